encoder83_irq: RTL and testbench



---
 rtl/enc83_pkg.sv | 22 ++
 rtl/prio_enc83.sv | 29 ++
 rtl/encoder83_irq.sv | 149 ++++++++++++++
 tb/tb_encoder83_irq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/enc83_pkg.sv
// Shared definitions for the 8-to-3 request encoder: widths, FSM states and
// the default synchronizer depth.
package enc83_pkg;

    localparam int CODE_W          = 3;
    localparam int REQ_W           = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } enc_state_e;

    // One-hot mask selecting the pending bit addressed by a code.
    function automatic logic [REQ_W-1:0] code_mask(input logic [CODE_W-1:0] code);
        logic [REQ_W-1:0] mask;
        mask       = '0;
        mask[code] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/prio_enc83.sv
// Combinational 8-bit priority encoder with a rotating start index.
// A start index of 0 gives fixed priority with bit 0 highest.
module prio_enc83
    import enc83_pkg::*;
(
    input  logic [REQ_W-1:0]  vec,
    input  logic [CODE_W-1:0] start,
    output logic [CODE_W-1:0] code,
    output logic              any_set
);

    logic [CODE_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch to hold it.
    always_comb begin
        code    = '0;
        any_set = 1'b0;
        idx     = '0;
        for (int i = 0; i < REQ_W; i++) begin
            idx = start + CODE_W'(i);
            if (!any_set && vec[idx]) begin
                code    = idx;
                any_set = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder83_irq.sv
// Registered 8-to-3 request encoder with valid/ready handshake.
// Define ENC83_RR_EN for round-robin selection; default is lowest index first.
module encoder83_irq
    import enc83_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF   // legal 2..4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REQ_W-1:0]  i_req_n,
    output logic [CODE_W-1:0] o_code,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [REQ_W-1:0]  o_pending,
    output logic              o_overrun
);

    localparam int          WARM_CYCLES = SYNC_STAGES + 1;
    localparam logic [2:0]  WARM_DONE   = 3'(WARM_CYCLES);

    logic [SYNC_STAGES-1:0][REQ_W-1:0] sync_q;
    logic [REQ_W-1:0]                  prev_q;
    logic [2:0]                        warm_cnt_q;
    logic                              armed;

    logic [REQ_W-1:0]  edge_ev;
    logic [REQ_W-1:0]  clr_mask;
    logic [REQ_W-1:0]  pend_q, pend_d;
    logic              ovr_q, ovr_d;
    logic              accept;

    enc_state_e        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;

    logic [CODE_W-1:0] sel_start;
    logic [CODE_W-1:0] sel_code;
    logic              sel_any;

    // NOTE: synchronizer and edge flops reset to the inactive level (1) so
    // that leaving reset can never look like a falling request edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '1;
            prev_q <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its neighbours.
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_req_n};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Lines already low when reset is released must not raise an event: edge
    // detection stays masked until the synchronizer has flushed its reset 1s.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            warm_cnt_q <= '0;
        end else if (!armed) begin
            warm_cnt_q <= warm_cnt_q + 3'd1;
        end
    end

    assign armed    = (warm_cnt_q == WARM_DONE);
    assign edge_ev  = armed ? (prev_q & ~sync_q[SYNC_STAGES-1]) : '0;
    assign accept   = i_ready & valid_q;
    assign clr_mask = accept ? code_mask(code_q) : '0;

    // Set beats clear: a fresh edge on the bit being accepted stays pending.
    assign pend_d = (pend_q & ~clr_mask) | edge_ev;
    assign ovr_d  = |(edge_ev & pend_q & ~clr_mask);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= '0;
            ovr_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

`ifdef ENC83_RR_EN
    logic [CODE_W-1:0] ptr_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q <= CODE_W'(REQ_W - 1);
        end else if (accept) begin
            ptr_q <= code_q;
        end
    end

    assign sel_start = ptr_q + CODE_W'(1);
`else
    assign sel_start = '0;
`endif

    prio_enc83 u_prio (
        .vec     (pend_q),
        .start   (sel_start),
        .code    (sel_code),
        .any_set (sel_any)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    code_d  = sel_code;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // Grant is held stable until the consumer takes it.
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign o_code    = code_q;
    assign o_valid   = valid_q;
    assign o_pending = pend_q;
    assign o_overrun = ovr_q;

endmodule

// File: tb/tb_encoder83_irq.sv
// Directed bench for encoder83_irq: stimulus table plus hand-written corner
// sequences. Expected codes follow ENC83_RR_EN when it is defined.
module tb_encoder83_irq;

`ifdef ENC83_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] req_n;
    logic       ready;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    encoder83_irq #(.SYNC_STAGES(2)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req_n   (req_n),
        .o_code    (code),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_pending (pending),
        .o_overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req_n;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic [7:0] exp_pend;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [7:0] r, logic rd, logic v, logic [2:0] c,
                                logic [7:0] p, logic o);
        vec_t t;
        t.req_n     = r;
        t.ready     = rd;
        t.exp_valid = v;
        t.exp_code  = c;
        t.exp_pend  = p;
        t.exp_ovr   = o;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!valid && n < max_cycles) begin
            step();
            n++;
        end
        check({name, "_valid_timeout"}, 32'(valid), 32'd1);
    endtask

    logic [2:0] first_code, second_code;
    logic [7:0] mid_pend;
    int         cnt;

    initial begin
        rst_n = 1'b0;
        req_n = 8'hFF;
        ready = 1'b0;

        #2;
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_code",    32'(code),    32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("quiet%0d", i), {23'd0, valid, pending, overrun}, 32'd0);
        end

        // Priority order for simultaneous falls on bits 5 and 2; in the
        // round-robin build the pointer sits at 3 after the first grant.
        first_code  = RR ? 3'd5 : 3'd2;
        second_code = RR ? 3'd2 : 3'd5;
        mid_pend    = RR ? 8'h04 : 8'h20;

        vecs.push_back(mk(8'hF7, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hF7, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hF7, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0));
        vecs.push_back(mk(8'hF7, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0));
        vecs.push_back(mk(8'hF7, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hF7, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hDB, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hDB, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hDB, 1'b1, 1'b0, 3'd0, 8'h24, 1'b0));
        vecs.push_back(mk(8'hDB, 1'b1, 1'b1, first_code, 8'h24, 1'b0));
        vecs.push_back(mk(8'hDB, 1'b1, 1'b0, 3'd0, mid_pend, 1'b0));
        vecs.push_back(mk(8'hDB, 1'b1, 1'b1, second_code, mid_pend, 1'b0));
        vecs.push_back(mk(8'hDB, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        vecs.push_back(mk(8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));

        foreach (vecs[i]) begin
            req_n = vecs[i].req_n;
            ready = vecs[i].ready;
            step();
            check($sformatf("vec%0d_valid", i),   32'(valid),   32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pend));
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].exp_ovr));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d_code", i), 32'(code), 32'(vecs[i].exp_code));
        end

        // Overrun: bit 1 re-falls while its grant is still waiting.
        ready = 1'b0;
        req_n = 8'hFD;
        wait_valid("ovr_first", 10);
        check("ovr_code", 32'(code), 32'd1);
        req_n = 8'hFF;
        repeat (3) step();
        req_n = 8'hFD;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (overrun) cnt++;
        end
        check("ovr_pulses", 32'(cnt), 32'd1);
        check("ovr_hold_valid", 32'(valid), 32'd1);
        check("ovr_hold_code", 32'(code), 32'd1);
        check("ovr_pending", 32'(pending), 32'h02);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("ovr_acc_valid", 32'(valid), 32'd0);
        check("ovr_acc_pending", 32'(pending), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (valid) cnt++;
        end
        check("ovr_single_grant", 32'(cnt), 32'd0);
        req_n = 8'hFF;
        repeat (3) step();

        // Set and clear of bit 4 in the same cycle.
        req_n = 8'hEF;
        wait_valid("sc_first", 10);
        check("sc_code", 32'(code), 32'd4);
        req_n = 8'hFF;
        repeat (3) step();
        check("sc_hold_pending", 32'(pending), 32'h10);
        req_n = 8'hEF;
        step();
        step();
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("sc_acc_valid", 32'(valid), 32'd0);
        check("sc_acc_pending", 32'(pending), 32'h10);
        check("sc_acc_overrun", 32'(overrun), 32'd0);
        step();
        check("sc_regrant_valid", 32'(valid), 32'd1);
        check("sc_regrant_code", 32'(code), 32'd4);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check("sc_final_valid", 32'(valid), 32'd0);
        check("sc_final_pending", 32'(pending), 32'd0);
        req_n = 8'hFF;
        repeat (3) step();

        // Reset while a grant is offered, lines held low across release.
        req_n = 8'h7F;
        wait_valid("rst_mid", 10);
        check("rst_mid_code", 32'(code), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid_now", 32'(valid), 32'd0);
        check("rst_mid_code_now", 32'(code), 32'd0);
        check("rst_mid_pending_now", 32'(pending), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (valid || pending != 8'h00 || overrun) cnt++;
        end
        check("rst_release_no_grant", 32'(cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
